// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the systolic array job sequencer.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Precision encodings carried on the width config fields
  localparam logic [3:0] W1 = 4'd1;
  localparam logic [3:0] W2 = 4'd2;
  localparam logic [3:0] W4 = 4'd4;
  localparam logic [3:0] W8 = 4'd8;

  typedef struct packed {
    logic [3:0] in_w;
    logic [3:0] wt_w;
    logic       s_in;
    logic       s_wt;
  } sa_cfg_t;

  localparam sa_cfg_t CFG_RST = '{in_w: W1, wt_w: W1, s_in: 1'b0, s_wt: 1'b0};

  function automatic int widx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WIDX_W = widx_w(8);

endpackage

// File: rtl/sa_valid_delay.sv
// Fixed-latency {valid,addr} shift register that tracks rows through the array pipeline.
module sa_valid_delay #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_empty
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;
  logic [DEPTH-1:0]            w_vld_nxt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Valid bits as they stand after the next shift; the final stage drops out,
  // so empty here means the last live row is being presented right now.
  always_comb begin
    w_vld_nxt    = '0;
    w_vld_nxt[0] = i_d[WIDTH-1];
    for (int i = 1; i < DEPTH; i++) w_vld_nxt[i] = r_pipe[i-1][WIDTH-1];
  end

  assign o_empty = ~|w_vld_nxt;
  assign o_q     = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: preloads weight rows, streams input rows, strobes result writes
// when each row's psums leave the array pipeline.
module systolic_array_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter  int ARRAY_SIZE = 8,
  parameter  int ADDR_W     = 8,
  parameter  int PIPE_LAT   = 9,
  localparam int IDX_W      = widx_w(ARRAY_SIZE),
  localparam int DW         = 8 * ARRAY_SIZE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_num_rows,
  input  logic [3:0]        i_cfg_in_width,
  input  logic [3:0]        i_cfg_wt_width,
  input  logic              i_cfg_s_in,
  input  logic              i_cfg_s_weight,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wbuf_rd,
  output logic [IDX_W-1:0]  o_wbuf_addr,
  input  logic [DW-1:0]     i_wbuf_rdata,
  output logic              o_ibuf_rd,
  output logic [ADDR_W-1:0] o_ibuf_addr,
  input  logic [DW-1:0]     i_ibuf_rdata,
  output logic              o_sa_w_row_we,
  output logic [IDX_W-1:0]  o_sa_w_row_idx,
  output logic [DW-1:0]     o_sa_w_row,
  output logic [DW-1:0]     o_sa_inputs,
  output logic              o_sa_in_valid,
  output logic [3:0]        o_sa_in_width,
  output logic [3:0]        o_sa_weight_width,
  output logic              o_sa_s_in,
  output logic              o_sa_s_weight,
  output logic              o_res_we,
  output logic [ADDR_W-1:0] o_res_addr
);

  state_e              r_state, w_state_nxt;
  sa_cfg_t             r_cfg;
  logic [IDX_W:0]      r_wcnt;
  logic [ADDR_W:0]     r_row;   // one spare bit so N = 2**ADDR_W-1 never wraps
  logic [ADDR_W:0]     r_num;
  logic                r_w_we;
  logic [IDX_W-1:0]    r_w_idx;
  logic [DW-1:0]       r_w_row;
  logic [DW-1:0]       r_inputs;
  logic                r_in_valid;
  logic [ADDR_W-1:0]   r_in_row;

  logic                w_wbuf_rd;
  logic                w_ibuf_rd;
  logic [IDX_W-1:0]    w_wbuf_addr;
  logic [ADDR_W-1:0]   w_ibuf_addr;
  logic [ADDR_W:0]     w_dly_q;
  logic                w_dly_empty;

  assign w_wbuf_rd   = (r_state == LOAD_W) && (r_wcnt < (IDX_W+1)'(ARRAY_SIZE));
  assign w_ibuf_rd   = (r_state == STREAM);
  assign w_wbuf_addr = w_wbuf_rd ? r_wcnt[IDX_W-1:0] : '0;
  assign w_ibuf_addr = w_ibuf_rd ? r_row[ADDR_W-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = (i_num_rows == '0) ? DONE : LOAD_W;
      // LOAD_W lingers one cycle past the last read so its row write lands first
      LOAD_W:  if (r_wcnt == (IDX_W+1)'(ARRAY_SIZE)) w_state_nxt = STREAM;
      STREAM:  if (r_row + 1'b1 == r_num) w_state_nxt = DRAIN;
      DRAIN:   if (w_dly_empty) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg      <= CFG_RST;
      r_num      <= '0;
      r_wcnt     <= '0;
      r_row      <= '0;
      r_w_we     <= 1'b0;
      r_w_idx    <= '0;
      r_w_row    <= '0;
      r_inputs   <= '0;
      r_in_valid <= 1'b0;
      r_in_row   <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_cfg <= '{in_w: i_cfg_in_width, wt_w: i_cfg_wt_width,
                   s_in: i_cfg_s_in, s_wt: i_cfg_s_weight};
        r_num <= {1'b0, i_num_rows};
      end
      r_wcnt     <= (r_state == LOAD_W) ? r_wcnt + 1'b1 : '0;
      r_row      <= (r_state == STREAM) ? r_row + 1'b1 : '0;
      r_w_we     <= w_wbuf_rd;
      r_w_idx    <= w_wbuf_addr;
      r_in_valid <= w_ibuf_rd;
      r_in_row   <= w_ibuf_addr;
      if (w_wbuf_rd) r_w_row  <= i_wbuf_rdata;
      if (w_ibuf_rd) r_inputs <= i_ibuf_rdata;
    end
  end

  sa_valid_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (1 + ADDR_W)
  ) u_dly (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_d     ({r_in_valid, r_in_row}),
    .o_q     (w_dly_q),
    .o_empty (w_dly_empty)
  );

  assign o_busy            = (r_state != IDLE);
  assign o_done            = (r_state == DONE);
  assign o_wbuf_rd         = w_wbuf_rd;
  assign o_wbuf_addr       = w_wbuf_addr;
  assign o_ibuf_rd         = w_ibuf_rd;
  assign o_ibuf_addr       = w_ibuf_addr;
  assign o_sa_w_row_we     = r_w_we;
  assign o_sa_w_row_idx    = r_w_idx;
  assign o_sa_w_row        = r_w_row;
  assign o_sa_inputs       = r_inputs;
  assign o_sa_in_valid     = r_in_valid;
  assign o_sa_in_width     = r_cfg.in_w;
  assign o_sa_weight_width = r_cfg.wt_w;
  assign o_sa_s_in         = r_cfg.s_in;
  assign o_sa_s_weight     = r_cfg.s_wt;
  assign o_res_we          = w_dly_q[ADDR_W];
  assign o_res_addr        = w_dly_q[ADDR_W-1:0];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized bench: cycle-window timing model plus a psum scoreboard against a plain matmul.
module tb_systolic_array_ctrl;

  localparam int AS = 8;
  localparam int AW = 8;
  localparam int L  = 9;
  localparam int IW = $clog2(AS);
  localparam int DW = 8 * AS;
  localparam int VW = 7 + 2*IW + 2*AW;
  localparam logic [9:0] CFG_RST = {4'd1, 4'd1, 1'b0, 1'b0};

  typedef logic [AS-1:0][31:0] psum_t;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] num_rows = '0;
  logic [3:0]    cfg_iw = 4'd8, cfg_ww = 4'd8;
  logic          cfg_si = 1'b1, cfg_sw = 1'b1;
  logic          busy, done, wbuf_rd, ibuf_rd, w_we, in_valid, res_we;
  logic [IW-1:0] wbuf_addr, w_idx;
  logic [AW-1:0] ibuf_addr, res_addr;
  logic [DW-1:0] wbuf_rdata, ibuf_rdata, w_row, inputs;
  logic [3:0]    sa_iw, sa_ww;
  logic          sa_si, sa_sw;

  logic [DW-1:0] wmem  [AS];
  logic [DW-1:0] imem  [1<<AW];
  logic [DW-1:0] wregs [AS];
  psum_t         exp_q [$];
  psum_t         arr_q [$];

  int         cyc = 0, tests = 0, errs = 0;
  bit         mon_en = 1'b0;
  int         j_t0 = -100000, j_n = 0, j_abort = 1 << 30;
  logic [9:0] j_cfg = CFG_RST, p_cfg = CFG_RST;

  assign wbuf_rdata = wmem[wbuf_addr];
  assign ibuf_rdata = imem[ibuf_addr];

  systolic_array_ctrl #(.ARRAY_SIZE(AS), .ADDR_W(AW), .PIPE_LAT(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_rows(num_rows),
    .i_cfg_in_width(cfg_iw), .i_cfg_wt_width(cfg_ww),
    .i_cfg_s_in(cfg_si), .i_cfg_s_weight(cfg_sw),
    .o_busy(busy), .o_done(done),
    .o_wbuf_rd(wbuf_rd), .o_wbuf_addr(wbuf_addr), .i_wbuf_rdata(wbuf_rdata),
    .o_ibuf_rd(ibuf_rd), .o_ibuf_addr(ibuf_addr), .i_ibuf_rdata(ibuf_rdata),
    .o_sa_w_row_we(w_we), .o_sa_w_row_idx(w_idx), .o_sa_w_row(w_row),
    .o_sa_inputs(inputs), .o_sa_in_valid(in_valid),
    .o_sa_in_width(sa_iw), .o_sa_weight_width(sa_ww),
    .o_sa_s_in(sa_si), .o_sa_s_weight(sa_sw),
    .o_res_we(res_we), .o_res_addr(res_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at cyc %0d: got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic psum_t mm(input logic [DW-1:0] x, input logic [DW-1:0] w [AS]);
    psum_t r;
    for (int j = 0; j < AS; j++) begin
      int acc = 0;
      for (int k = 0; k < AS; k++)
        acc += int'($signed(x[8*k +: 8])) * int'($signed(w[k][8*j +: 8]));
      r[j] = acc;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int job_len(input int n);
    return (n == 0) ? 1 : AS + 3 + n + L;
  endfunction

  // Expected strobes/addresses in cycle c from the job's start cycle alone
  function automatic logic [VW-1:0] exp_vec(input int c);
    int   d = (c > j_abort) ? -1 : c - j_t0;
    logic b, dn, wr, we, ir, iv, rw;
    if (j_n == 0) begin
      b = (d == 1); dn = (d == 1);
      wr = 0; we = 0; ir = 0; iv = 0; rw = 0;
    end else begin
      b  = (d >= 1) && (d <= job_len(j_n));
      dn = (d == job_len(j_n));
      wr = (d >= 1) && (d <= AS);
      we = (d >= 2) && (d <= AS + 1);
      ir = (d >= AS + 2) && (d <= AS + 1 + j_n);
      iv = (d >= AS + 3) && (d <= AS + 2 + j_n);
      rw = (d >= AS + 3 + L) && (d <= AS + 2 + j_n + L);
    end
    return {b, dn, wr, wr ? IW'(d - 1) : IW'(0), we, we ? IW'(d - 2) : IW'(0),
            ir, ir ? AW'(d - AS - 2) : AW'(0), iv, rw, rw ? AW'(d - AS - 3 - L) : AW'(0)};
  endfunction

  function automatic logic [9:0] exp_cfg(input int c);
    if (c > j_abort) return CFG_RST;
    return (c > j_t0) ? j_cfg : p_cfg;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobes", {busy, done, wbuf_rd, wbuf_rd ? wbuf_addr : IW'(0),
                      w_we, w_we ? w_idx : IW'(0), ibuf_rd, ibuf_rd ? ibuf_addr : AW'(0),
                      in_valid, res_we, res_we ? res_addr : AW'(0)}, exp_vec(cyc));
      chk("cfg", {sa_iw, sa_ww, sa_si, sa_sw}, exp_cfg(cyc));
      if (w_we) wregs[w_idx] = w_row;
      if (in_valid) arr_q.push_back(mm(inputs, wregs));
      if (res_we) begin
        if (arr_q.size() == 0 || exp_q.size() == 0) begin
          tests++; errs++;
          $display("FAIL psum_avail at cyc %0d: got res_we with array=%0d expected=%0d rows queued",
                   cyc, arr_q.size(), exp_q.size());
        end else begin
          chk("psum", arr_q.pop_front(), exp_q.pop_front());
        end
      end
      if (rst) arr_q.delete();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input logic [3:0] iw, input logic [3:0] ww,
                           input logic si, input logic sw);
    for (int i = 0; i < AS; i++) wmem[i] = rnd_row();
    for (int i = 0; i < n; i++) imem[i] = rnd_row();
    for (int i = 0; i < n; i++) exp_q.push_back(mm(imem[i], wmem));
    p_cfg   = (cyc > j_abort) ? CFG_RST : exp_cfg(cyc);
    j_cfg   = {iw, ww, si, sw};
    j_t0    = cyc;
    j_n     = n;
    j_abort = 1 << 30;
    start = 1'b1; num_rows = AW'(n);
    cfg_iw = iw; cfg_ww = ww; cfg_si = si; cfg_sw = sw;
    tick(1);
    start = 1'b0;
    num_rows = AW'($urandom); cfg_iw = 4'($urandom); cfg_ww = 4'($urandom);
    cfg_si = 1'($urandom); cfg_sw = 1'($urandom);
  endtask

  task automatic wait_idle();
    tick(j_t0 + job_len(j_n) + 1 - cyc);
  endtask

  initial begin
    for (int i = 0; i < AS; i++) wmem[i] = rnd_row();
    for (int i = 0; i < (1 << AW); i++) imem[i] = rnd_row();
    tick(3);
    mon_en = 1'b1;
    chk("rst_data", {w_row, inputs, res_addr}, '0);
    rst = 1'b0;
    tick(2);

    start_job(4, 4'd8, 4'd8, 1'b1, 1'b1);
    wait_idle(); tick(2);

    start_job(0, 4'd8, 4'd8, 1'b1, 1'b1);
    wait_idle(); tick(2);

    start_job(4, 4'd8, 4'd8, 1'b1, 1'b1);
    tick(j_t0 + 5 - cyc);
    start = 1'b1; cfg_iw = 4'd2; cfg_ww = 4'd2; num_rows = AW'(9);
    tick(1);
    start = 1'b0;
    wait_idle(); tick(2);

    start_job(4, 4'd8, 4'd8, 1'b1, 1'b1);
    tick(j_t0 + 12 - cyc);
    rst = 1'b1; j_abort = cyc; exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(20);
    start_job(4, 4'd8, 4'd8, 1'b1, 1'b1);
    wait_idle();

    start_job(4, 4'd1, 4'd4, 1'b0, 1'b0);
    wait_idle(); tick(2);

    start_job(255, 4'd8, 4'd8, 1'b1, 1'b1);
    wait_idle(); tick(3);

    chk("sb_drained", 256'(exp_q.size()), 256'(0));
    chk("arr_drained", 256'(arr_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
